trigger_scheduler: RTL

- Front end of the processing element. Each cycle it picks the highest-priority triggered instruction whose predicate, channel and hazard conditions hold, and registers its index into the issue stage.
- It consumes the architectural predicate vector that the downstream predicate unit writes back.
- It tracks in-flight predicate writes and channel activity so no instruction fires on stale state.

---
 rtl/trigger_scheduler_pkg.sv | 25 ++
 rtl/trigger_scheduler_priority_encoder.sv | 25 ++
 rtl/trigger_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/trigger_scheduler_pkg.sv
// Shared control types and constants for the triggered-instruction scheduler.
// The per-slot trigger fields are grouped so the top can treat a slot as one unit.
package trigger_scheduler_pkg;

    localparam int TIA_NUM_PREDICATES      = 8;
    localparam int TIA_NUM_INSTRUCTIONS    = 16;
    localparam int TIA_NUM_INPUT_CHANNELS  = 4;
    localparam int TIA_NUM_OUTPUT_CHANNELS = 4;

    typedef enum logic [0:0] {
        SCHED_RUN    = 1'b0,
        SCHED_HALTED = 1'b1
    } scheduler_state_t;

    typedef struct packed {
        logic                               valid;
        logic [TIA_NUM_PREDICATES-1:0]      ptm_true;
        logic [TIA_NUM_PREDICATES-1:0]      ptm_false;
        logic [TIA_NUM_INPUT_CHANNELS-1:0]  ici;
        logic [TIA_NUM_OUTPUT_CHANNELS-1:0] oci;
        logic [TIA_NUM_PREDICATES-1:0]      pwm;
        logic                               halt;
    } trigger_fields_t;

endpackage

// File: rtl/trigger_scheduler_priority_encoder.sv
// Fixed-priority encoder: binary index of the lowest set request bit plus an any flag.
module trigger_scheduler_priority_encoder #(
    parameter  int N = 16,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    // NOTE: every output gets a default before the loop, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        // Scanning downward lets the lowest requesting index overwrite last.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trigger_scheduler.sv
// Triggered-instruction scheduler: picks the lowest eligible slot each cycle and registers it,
// while tracking in-flight predicate writes and recent channel use.
module trigger_scheduler
    import trigger_scheduler_pkg::*;
#(
    parameter  int NUM_INSTRUCTIONS    = TIA_NUM_INSTRUCTIONS,
    parameter  int NUM_PREDICATES      = TIA_NUM_PREDICATES,
    parameter  int NUM_INPUT_CHANNELS  = TIA_NUM_INPUT_CHANNELS,
    parameter  int NUM_OUTPUT_CHANNELS = TIA_NUM_OUTPUT_CHANNELS,
    parameter  int PRED_LATENCY        = 2,
    localparam int IDX_W = (NUM_INSTRUCTIONS > 1) ? $clog2(NUM_INSTRUCTIONS) : 1
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          enable,
    input  logic [NUM_PREDICATES-1:0]                     predicates,
    input  logic [NUM_INSTRUCTIONS-1:0]                   slot_valid,
    input  logic [NUM_INSTRUCTIONS*NUM_PREDICATES-1:0]    slot_ptm_true,
    input  logic [NUM_INSTRUCTIONS*NUM_PREDICATES-1:0]    slot_ptm_false,
    input  logic [NUM_INSTRUCTIONS*NUM_INPUT_CHANNELS-1:0]  slot_ici_mask,
    input  logic [NUM_INSTRUCTIONS*NUM_OUTPUT_CHANNELS-1:0] slot_oci_mask,
    input  logic [NUM_INSTRUCTIONS*NUM_PREDICATES-1:0]    slot_pwm,
    input  logic [NUM_INSTRUCTIONS-1:0]                   slot_halt,
    input  logic [NUM_INPUT_CHANNELS-1:0]                 input_channel_empty,
    input  logic [NUM_OUTPUT_CHANNELS-1:0]                output_channel_full,
    output logic                                          issue_valid,
    output logic [IDX_W-1:0]                              issue_index,
    output logic                                          halted
);

    scheduler_state_t r_state, w_state_next;

    logic [NUM_PREDICATES-1:0]      r_pend [PRED_LATENCY];
    logic [NUM_INPUT_CHANNELS-1:0]  r_in_shadow;
    logic [NUM_OUTPUT_CHANNELS-1:0] r_out_shadow;
    logic                           r_issue_valid;
    logic [IDX_W-1:0]               r_issue_index;

    trigger_fields_t                w_slot [NUM_INSTRUCTIONS];
    logic [NUM_PREDICATES-1:0]      w_pending_mask;
    logic [NUM_INSTRUCTIONS-1:0]    w_req;
    logic [IDX_W-1:0]               w_idx;
    logic                           w_any;

    for (genvar g = 0; g < NUM_INSTRUCTIONS; g++) begin : g_unpack
        assign w_slot[g].valid     = slot_valid[g];
        assign w_slot[g].ptm_true  = slot_ptm_true[g*NUM_PREDICATES +: NUM_PREDICATES];
        assign w_slot[g].ptm_false = slot_ptm_false[g*NUM_PREDICATES +: NUM_PREDICATES];
        assign w_slot[g].ici       = slot_ici_mask[g*NUM_INPUT_CHANNELS +: NUM_INPUT_CHANNELS];
        assign w_slot[g].oci       = slot_oci_mask[g*NUM_OUTPUT_CHANNELS +: NUM_OUTPUT_CHANNELS];
        assign w_slot[g].pwm       = slot_pwm[g*NUM_PREDICATES +: NUM_PREDICATES];
        assign w_slot[g].halt      = slot_halt[g];
    end

    always_comb begin
        w_pending_mask = '0;
        for (int s = 0; s < PRED_LATENCY; s++) begin
            w_pending_mask = w_pending_mask | r_pend[s];
        end
    end

    // A slot is blocked by any predicate it tests that still has a write in flight,
    // and by any channel touched by the previous winner.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_INSTRUCTIONS; i++) begin
            w_req[i] = (r_state == SCHED_RUN)
                && w_slot[i].valid
                && ((predicates & w_slot[i].ptm_true) == w_slot[i].ptm_true)
                && ((predicates & w_slot[i].ptm_false) == '0)
                && (((w_slot[i].ptm_true | w_slot[i].ptm_false) & w_pending_mask) == '0)
                && ((w_slot[i].ici & (input_channel_empty | r_in_shadow)) == '0)
                && ((w_slot[i].oci & (output_channel_full | r_out_shadow)) == '0);
        end
    end

    trigger_scheduler_priority_encoder #(
        .N (NUM_INSTRUCTIONS)
    ) u_prio (
        .i_req (w_req),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_state_next = r_state;
        if (r_state == SCHED_RUN && w_any && w_slot[w_idx].halt) begin
            w_state_next = SCHED_HALTED;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= SCHED_RUN;
        end else if (enable) begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the pending pipeline is a handful of flops, not a RAM, so it is cleared on reset
    // like any other state; a stale pending bit would wrongly block slots after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_issue_valid <= 1'b0;
            r_issue_index <= '0;
            r_in_shadow   <= '0;
            r_out_shadow  <= '0;
            for (int s = 0; s < PRED_LATENCY; s++) begin
                r_pend[s] <= '0;
            end
        end else if (enable) begin
            // NOTE: non-blocking assignments make every stage shift from its pre-edge value.
            r_issue_valid <= w_any;
            if (w_any) begin
                r_issue_index <= w_idx;
            end
            r_pend[0]    <= w_any ? w_slot[w_idx].pwm : '0;
            r_in_shadow  <= w_any ? w_slot[w_idx].ici : '0;
            r_out_shadow <= w_any ? w_slot[w_idx].oci : '0;
            for (int s = 1; s < PRED_LATENCY; s++) begin
                r_pend[s] <= r_pend[s-1];
            end
        end
    end

    assign issue_valid = r_issue_valid & enable;
    assign issue_index = r_issue_index;
    assign halted      = (r_state == SCHED_HALTED);

endmodule
